l0_feeder: RTL and testbench

L0_FEEDER -- requirements
Module: l0_feeder

---
 rtl/l0_feeder.sv | 96 +++++++++
 tb/tb_l0_feeder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/l0_feeder.sv
// rtl/l0_feeder.sv - streams SRAM activation words into the L0 row FIFOs, then drains L0 into the array
module l0_feeder #(
  parameter int row     = 8,
  parameter int bw      = 4,
  parameter int addr_bw = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [addr_bw-1:0]     base_addr,
  input  logic [6:0]             len,
  output logic                   sram_cen,
  output logic [addr_bw-1:0]     sram_addr,
  input  logic [row*bw-1:0]      sram_dout,
  output logic [row*bw-1:0]      l0_in,
  output logic                   l0_wr,
  input  logic                   l0_full,
  output logic                   l0_rd,
  input  logic                   drain_en,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t               state, state_nx;
  logic [addr_bw-1:0]   base_q, addr_q;
  logic [6:0]           len_q, issued, written, drained;
  logic                 pend, skid_vld;
  logic [row*bw-1:0]    skid_data;
  logic                 issue, wr_skid, wr_direct, to_skid, rd;

  always_comb begin
    // a word returning while L0 is full parks in the skid; no new read until it drains
    issue     = (state == LOAD) && (issued < len_q) && !l0_full && !skid_vld;
    wr_skid   = skid_vld && !l0_full;
    wr_direct = pend && !skid_vld && !l0_full;
    to_skid   = pend && l0_full;
    rd        = (state == DRAIN) && (drained < len_q) && drain_en;

    sram_cen  = !issue;
    sram_addr = issue ? (base_q + addr_bw'(issued)) : addr_q;
    l0_wr     = wr_skid || wr_direct;
    l0_in     = wr_skid ? skid_data : (wr_direct ? sram_dout : '0);
    l0_rd     = rd;
    busy      = (state != IDLE);
    done      = (state == DONE);

    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = (len == 7'd0) ? DONE : LOAD;
      LOAD:  if ((written + {6'd0, l0_wr}) == len_q) state_nx = DRAIN;
      DRAIN: if ((drained + {6'd0, rd}) == len_q) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      base_q    <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      issued    <= '0;
      written   <= '0;
      drained   <= '0;
      pend      <= 1'b0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
    end else begin
      state <= state_nx;
      pend  <= issue;
      if (issue) begin
        issued <= issued + 7'd1;
        addr_q <= sram_addr;
      end
      if (l0_wr) written <= written + 7'd1;
      if (rd) drained <= drained + 7'd1;
      if (to_skid) begin
        skid_vld  <= 1'b1;
        skid_data <= sram_dout;
      end else if (wr_skid) begin
        skid_vld <= 1'b0;
      end
      if (state == IDLE && start) begin
        base_q  <= base_addr;
        len_q   <= len;
        issued  <= '0;
        written <= '0;
        drained <= '0;
      end
    end
  end

endmodule

// File: tb/tb_l0_feeder.sv
// tb/tb_l0_feeder.sv - scoreboard bench for l0_feeder: address order, write data, drain handshake, reset
module tb_l0_feeder;

  logic        clk = 1'b0;
  logic        reset, start, l0_full, drain_en;
  logic [10:0] base_addr, sram_addr;
  logic [6:0]  len;
  logic        sram_cen, l0_wr, l0_rd, busy, done;
  logic [31:0] sram_dout, l0_in;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_cnt, rd_cnt, done_cnt, cen_cnt, busy_cnt;
  logic [10:0] last_addr = '0;
  logic        rst_q = 1'b0;
  logic [10:0] addr_q[$];
  logic [31:0] data_q[$];

  l0_feeder #(.row(8), .bw(4), .addr_bw(11)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
    .sram_cen(sram_cen), .sram_addr(sram_addr), .sram_dout(sram_dout),
    .l0_in(l0_in), .l0_wr(l0_wr), .l0_full(l0_full), .l0_rd(l0_rd),
    .drain_en(drain_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [10:0] a);
    return ({21'd0, a} * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  // SRAM model: one-cycle read latency, garbage when not enabled
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
    if (!sram_cen) sram_dout <= mem_f(sram_addr);
    else sram_dout <= $urandom;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_q) begin
      last_addr = '0;
      addr_q.delete();
      data_q.delete();
    end
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (!sram_cen) begin
      cen_cnt++;
      chk("issue_while_full", {31'd0, l0_full}, 32'd0);
      if (addr_q.size() == 0) chk("unexpected_issue", {21'd0, sram_addr}, 32'hFFFFFFFF);
      else chk("sram_addr", {21'd0, sram_addr}, {21'd0, addr_q.pop_front()});
      last_addr = sram_addr;
    end else begin
      chk("addr_hold", {21'd0, sram_addr}, {21'd0, last_addr});
    end
    if (l0_wr) begin
      wr_cnt++;
      chk("wr_while_full", {31'd0, l0_full}, 32'd0);
      if (data_q.size() == 0) chk("unexpected_write", l0_in, 32'hDEADBEEF ^ l0_in ^ 32'h1);
      else chk("l0_in", l0_in, data_q.pop_front());
    end else begin
      chk("l0_in_idle_zero", l0_in, 32'd0);
    end
    if (l0_rd) begin
      rd_cnt++;
      chk("rd_needs_drain_en", {31'd0, drain_en}, 32'd1);
    end
  end

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cen"}, {31'd0, sram_cen}, 32'd1);
    chk({tag, "_addr"}, {21'd0, sram_addr}, 32'd0);
    chk({tag, "_l0_in"}, l0_in, 32'd0);
    chk({tag, "_wr"}, {31'd0, l0_wr}, 32'd0);
    chk({tag, "_rd"}, {31'd0, l0_rd}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  task automatic begin_pass(input logic [10:0] b, input int l, input logic de);
    @(negedge clk);
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0; cen_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < l; i++) begin
      addr_q.push_back(11'(b + 11'(i)));
      data_q.push_back(mem_f(11'(b + 11'(i))));
    end
    start = 1'b1; base_addr = b; len = 7'(l); drain_en = de;
  endtask

  // mode 0 plain, 1 l0_full burst, 2 drain_en pattern, 3 stray start during LOAD
  task automatic run_pass(input logic [10:0] b, input int l, input int mode);
    int t1, k, pi;
    logic pat[7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    pi = 0;
    begin_pass(b, l, (mode == 2) ? 1'b0 : 1'b1);
    @(negedge clk);
    start = 1'b0; base_addr = 11'h555; len = 7'd3;
    t1 = cyc;
    if (l > 0) chk("first_issue_latency", {31'd0, sram_cen}, 32'd0);
    else chk("len0_done_next", {31'd0, done}, 32'd1);
    k = 0;
    while (!done && k < 2000) begin
      if (mode == 1 && k == 3) l0_full = 1'b1;
      if (mode == 1 && k == 6) l0_full = 1'b0;
      if (mode == 3 && k == 2) begin start = 1'b1; base_addr = 11'h300; len = 7'd5; end
      if (mode == 3 && k == 3) start = 1'b0;
      if (mode == 2 && wr_cnt == l) begin
        drain_en = (pi < 7) ? pat[pi] : 1'b1;
        pi++;
      end
      k++;
      @(negedge clk);
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    if (l > 0 && (mode == 0 || mode == 3)) chk("done_latency", 32'(cyc - t1), 32'(2 * l + 1));
    @(negedge clk);
    chk("wr_count", 32'(wr_cnt), 32'(l));
    chk("rd_count", 32'(rd_cnt), 32'(l));
    chk("issue_count", 32'(cen_cnt), 32'(l));
    chk("done_pulses", 32'(done_cnt), 32'd1);
    if (mode != 1 && mode != 2) chk("busy_cycles", 32'(busy_cnt), (l == 0) ? 32'd1 : 32'(2 * l + 2));
    chk("addr_q_empty", 32'(addr_q.size()), 32'd0);
    chk("data_q_empty", 32'(data_q.size()), 32'd0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
    drain_en = 1'b1;
    l0_full  = 1'b0;
  endtask

  task automatic reset_mid_load();
    int k;
    begin_pass(11'h100, 8, 1'b1);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (cen_cnt < 3 && k < 50) begin
      k++;
      @(negedge clk);
    end
    chk("three_issues_seen", 32'(cen_cnt), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_outs("mid_rst");
    wr_cnt = 0;
    repeat (4) @(negedge clk);
    chk("no_write_after_reset", 32'(wr_cnt), 32'd0);
    chk("idle_after_reset", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; len = '0;
    l0_full = 1'b0; drain_en = 1'b1;
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0; cen_cnt = 0; busy_cnt = 0;
    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    start = 1'b1; len = 7'd4;
    @(negedge clk);
    chk("start_under_reset", {31'd0, busy}, 32'd0);
    start = 1'b0; reset = 1'b0;
    @(negedge clk);

    run_pass(11'h010, 8, 0);
    run_pass(11'h020, 0, 0);
    run_pass(11'h040, 16, 1);
    run_pass(11'h200, 4, 2);
    run_pass(11'h080, 8, 3);
    run_pass(11'h7F0, 64, 0);
    reset_mid_load();
    run_pass(11'h7FF, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
